// File: rtl/i2c_config_sequencer_if.sv
// Transmitter-side bus of the I2C configuration sequencer.
// Carries the command pulses, the transfer operands and the transmitter handshake.
interface i2c_config_sequencer_if;
   logic       START;
   logic       STOP;
   logic       TX_RESET;
   logic [6:0] DEV_ADDR;
   logic [7:0] REG_ADDR;
   logic [7:0] DATA;
   logic       READY;
   logic       END;
   logic       ERROR;

   modport master (
      output START, STOP, TX_RESET, DEV_ADDR, REG_ADDR, DATA,
      input  READY, END, ERROR
   );

   modport slave (
      input  START, STOP, TX_RESET, DEV_ADDR, REG_ADDR, DATA,
      output READY, END, ERROR
   );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a register/data table and issues one I2C write per entry, with timeout and recovery.
// Define I2C_SEQ_RETRY_EN to retry a failed entry up to MAX_RETRY times before aborting.
module i2c_config_sequencer #(
   parameter logic [6:0]  DEV_ADDR_P     = 7'h1A,
   parameter int unsigned NUM_ENTRIES    = 11,
   parameter int unsigned GAP_CYCLES     = 20,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                  CLK_200KHZ,
   input  logic                  RESET,
   input  logic                  GO,
   input  logic [15:0]           TBL_DATA,
   output logic [5:0]            TBL_INDEX,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  FAIL,
   i2c_config_sequencer_if.master tx
);

   typedef enum logic [3:0] {
      IDLE, FETCH, ISSUE, WAIT_END, STOP_PULSE, RECOVER, GAP, FINISH, ABORT
   } state_t;

   localparam logic [5:0] LAST_INDEX = 6'(NUM_ENTRIES - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] index_q, index_d;
   logic [6:0] dev_q, dev_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] data_q, data_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       txr_q, txr_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fail_q, fail_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] tmo_q, tmo_d;
`ifdef I2C_SEQ_RETRY_EN
   logic [2:0] retry_q, retry_d;
`else
   // Retry limit has no effect when retries are compiled out.
   logic [2:0] unused_max_retry;
   assign unused_max_retry = 3'(MAX_RETRY);
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      index_d = index_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      data_d  = data_q;
      start_d = 1'b0;
      stop_d  = 1'b0;
      txr_d   = 1'b0;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
`ifdef I2C_SEQ_RETRY_EN
      retry_d = retry_q;
`endif

      case (state_q)
         IDLE, FINISH, ABORT: begin
            if (GO) begin
               state_d = FETCH;
               index_d = '0;
`ifdef I2C_SEQ_RETRY_EN
               retry_d = '0;
`endif
            end
         end
         FETCH: begin
            dev_d   = DEV_ADDR_P;
            reg_d   = TBL_DATA[15:8];
            data_d  = TBL_DATA[7:0];
            state_d = ISSUE;
         end
         ISSUE: begin
            if (tx.READY) begin
               start_d = 1'b1;
               tmo_d   = '0;
               state_d = WAIT_END;
            end
         end
         WAIT_END: begin
            if (tx.END && !tx.ERROR) begin
               stop_d  = 1'b1;
               state_d = STOP_PULSE;
            end else if (tx.END || tmo_q == TMO_LAST) begin
               txr_d   = 1'b1;
               state_d = RECOVER;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         STOP_PULSE: begin
            gap_d = '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_d = '0;
`endif
            if (index_q == LAST_INDEX) begin
               state_d = FINISH;
            end else begin
               index_d = index_q + 6'd1;
               state_d = GAP;
            end
         end
         RECOVER: begin
            gap_d = '0;
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q < 3'(MAX_RETRY)) begin
               retry_d = retry_q + 3'd1;
               state_d = GAP;
            end else begin
               state_d = ABORT;
            end
`else
            state_d = ABORT;
`endif
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = FETCH;
            else                   gap_d   = gap_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase

      // Status follows the state being entered so it is registered alongside it.
      busy_d = !(state_d inside {IDLE, FINISH, ABORT});
      done_d = (state_d == FINISH);
      fail_d = (state_d == ABORT);
   end

   always_ff @(posedge CLK_200KHZ) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (RESET) begin
         state_q <= IDLE;
         index_q <= '0;
         dev_q   <= '0;
         reg_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         txr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         gap_q   <= '0;
         tmo_q   <= '0;
`ifdef I2C_SEQ_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         start_q <= start_d;
         stop_q  <= stop_d;
         txr_q   <= txr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
`ifdef I2C_SEQ_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   assign TBL_INDEX   = index_q;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign FAIL        = fail_q;
   assign tx.START    = start_q;
   assign tx.STOP     = stop_q;
   assign tx.TX_RESET = txr_q;
   assign tx.DEV_ADDR = dev_q;
   assign tx.REG_ADDR = reg_q;
   assign tx.DATA     = data_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench for i2c_config_sequencer: transmitter model plus operand scoreboard.
// Expectations follow I2C_SEQ_RETRY_EN so the bench suits either build.
module tb_i2c_config_sequencer;

   localparam int unsigned NUM_ENTRIES = 3;
   localparam int unsigned GAP_CYCLES  = 20;
   localparam int          TX_LAT      = 6;
`ifdef I2C_SEQ_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
   localparam int ATTEMPTS = 4;
`else
   localparam bit RETRY_ON = 1'b0;
   localparam int ATTEMPTS = 1;
`endif

   typedef struct packed {
      logic [7:0] reg_addr;
      logic [7:0] data;
   } xfer_t;

   logic        CLK_200KHZ = 1'b0;
   logic        RESET;
   logic        GO;
   logic [15:0] TBL_DATA;
   logic [5:0]  TBL_INDEX;
   logic        BUSY;
   logic        DONE;
   logic        FAIL;

   i2c_config_sequencer_if bus ();

   i2c_config_sequencer #(.NUM_ENTRIES(NUM_ENTRIES)) dut (
      .CLK_200KHZ (CLK_200KHZ),
      .RESET      (RESET),
      .GO         (GO),
      .TBL_DATA   (TBL_DATA),
      .TBL_INDEX  (TBL_INDEX),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .FAIL       (FAIL),
      .tx         (bus)
   );

   always #5 CLK_200KHZ = ~CLK_200KHZ;

   logic [15:0] tbl [64];
   assign TBL_DATA = tbl[TBL_INDEX];

   int cyc = 0;
   always @(posedge CLK_200KHZ) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   xfer_t exp_q[$];
   int    nack_left = 0;
   bit    hang = 1'b0;
   bit    ready_low = 1'b0;
   int    start_count, stop_count, txr_count, viol_count = 0;
   int    last_stop_cyc, last_start_cyc, first_txr_cyc, min_gap;

   // Transmitter model and protocol monitor, evaluated on the falling edge.
   initial begin : xmtr
      int    remaining = 0;
      bit    busy_tx = 1'b0;
      bit    nack_now = 1'b0;
      bit    prev_start = 1'b0, prev_stop = 1'b0, prev_txr = 1'b0;
      xfer_t exp;
      bus.READY = 1'b1;
      bus.END   = 1'b0;
      bus.ERROR = 1'b0;
      forever begin
         @(negedge CLK_200KHZ);
         bus.END   = 1'b0;
         bus.ERROR = 1'b0;
         if ($countones({bus.START, bus.STOP, bus.TX_RESET}) > 1) viol_count++;
         if ((bus.START && prev_start) || (bus.STOP && prev_stop) || (bus.TX_RESET && prev_txr))
            viol_count++;
         if (TBL_INDEX > 6'(NUM_ENTRIES - 1)) viol_count++;
         prev_start = bus.START;
         prev_stop  = bus.STOP;
         prev_txr   = bus.TX_RESET;
         if (bus.STOP === 1'b1) begin
            stop_count++;
            last_stop_cyc = cyc;
         end
         if (bus.TX_RESET === 1'b1) begin
            txr_count++;
            if (txr_count == 1) first_txr_cyc = cyc;
         end
         if (RESET || bus.TX_RESET === 1'b1) begin
            busy_tx = 1'b0;
         end else if (bus.START === 1'b1) begin
            start_count++;
            if (last_stop_cyc >= 0 && (cyc - last_stop_cyc - 1) < min_gap)
               min_gap = cyc - last_stop_cyc - 1;
            last_start_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_start: unexpected START at index %0d", TBL_INDEX);
            end else begin
               exp = exp_q.pop_front();
               if ({bus.DEV_ADDR, bus.REG_ADDR, bus.DATA} !== {7'h1A, exp.reg_addr, exp.data}) begin
                  errors++;
                  $display("FAIL sb_operands: got dev=%h reg=%h data=%h, expected dev=1a reg=%h data=%h",
                           bus.DEV_ADDR, bus.REG_ADDR, bus.DATA, exp.reg_addr, exp.data);
               end
            end
            busy_tx   = 1'b1;
            remaining = TX_LAT;
            nack_now  = (TBL_INDEX == 6'd1 && nack_left > 0);
            if (nack_now) nack_left--;
         end else if (busy_tx && !hang) begin
            remaining--;
            if (remaining == 0) begin
               bus.END   = 1'b1;
               bus.ERROR = nack_now;
               busy_tx   = 1'b0;
            end
         end
         bus.READY = !busy_tx && !ready_low;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge CLK_200KHZ);
         #1;
      end
   endtask

   task automatic clear_stats();
      start_count   = 0;
      stop_count    = 0;
      txr_count     = 0;
      last_stop_cyc = -1;
      min_gap       = 1000;
      exp_q.delete();
   endtask

   task automatic push_entry(input int i);
      exp_q.push_back(xfer_t'(tbl[i]));
   endtask

   task automatic pulse_go();
      GO = 1'b1;
      tick();
      GO = 1'b0;
   endtask

   task automatic wait_run_end(input string name, input int budget);
      int n = 0;
      while (!(DONE || FAIL) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!(DONE || FAIL)) begin
         errors++;
         $display("FAIL %s_finish: no DONE/FAIL within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      GO    = 1'b1;
      tick(3);
      checks++;
      if ({bus.START, bus.STOP, bus.TX_RESET, BUSY, DONE, FAIL} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 000000",
                  {bus.START, bus.STOP, bus.TX_RESET, BUSY, DONE, FAIL});
      end
      checks++;
      if ({TBL_INDEX, bus.DEV_ADDR, bus.REG_ADDR, bus.DATA} !== 29'd0) begin
         errors++;
         $display("FAIL reset_operands: got idx=%0d dev=%h reg=%h data=%h, expected all 0",
                  TBL_INDEX, bus.DEV_ADDR, bus.REG_ADDR, bus.DATA);
      end
      GO    = 1'b0;
      RESET = 1'b0;
      tick(2);
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: BUSY=%b, expected 0", BUSY);
      end
   endtask

   task automatic test_basic_run();
      clear_stats();
      for (int i = 0; i < 3; i++) push_entry(i);
      pulse_go();
      checks++;
      if ({BUSY, DONE} !== 2'b10) begin
         errors++;
         $display("FAIL basic_busy: BUSY/DONE=%b, expected 10", {BUSY, DONE});
      end
      wait_run_end("basic", 400);
      checks++;
      if ({DONE, FAIL, BUSY} !== 3'b100) begin
         errors++;
         $display("FAIL basic_status: DONE/FAIL/BUSY=%b, expected 100", {DONE, FAIL, BUSY});
      end
      checks++;
      if (start_count != 3 || stop_count != 3 || txr_count != 0) begin
         errors++;
         $display("FAIL basic_pulses: start=%0d stop=%0d txr=%0d, expected 3 3 0",
                  start_count, stop_count, txr_count);
      end
      // Idle cycles between STOP and next START: GAP_CYCLES, FETCH, ISSUE.
      checks++;
      if (min_gap != GAP_CYCLES + 2) begin
         errors++;
         $display("FAIL basic_gap: got %0d idle cycles, expected %0d", min_gap, GAP_CYCLES + 2);
      end
      checks++;
      if (TBL_INDEX !== 6'd2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_index: idx=%0d pending=%0d, expected 2 0", TBL_INDEX, exp_q.size());
      end
      tick(5);
      checks++;
      if (DONE !== 1'b1) begin
         errors++;
         $display("FAIL basic_done_hold: DONE=%b, expected 1", DONE);
      end
   endtask

   task automatic test_nack_once();
      clear_stats();
      nack_left = 1;
      push_entry(0);
      push_entry(1);
      if (RETRY_ON) begin
         push_entry(1);
         push_entry(2);
      end
      pulse_go();
      wait_run_end("nack_once", 600);
      checks++;
      if ({DONE, FAIL} !== (RETRY_ON ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL nack_once_status: DONE/FAIL=%b, expected %b", {DONE, FAIL},
                  (RETRY_ON ? 2'b10 : 2'b01));
      end
      checks++;
      if (txr_count != 1 || start_count != (RETRY_ON ? 4 : 2) || exp_q.size() != 0) begin
         errors++;
         $display("FAIL nack_once_pulses: txr=%0d start=%0d pending=%0d, expected 1 %0d 0",
                  txr_count, start_count, exp_q.size(), (RETRY_ON ? 4 : 2));
      end
      checks++;
      if (TBL_INDEX !== (RETRY_ON ? 6'd2 : 6'd1)) begin
         errors++;
         $display("FAIL nack_once_index: idx=%0d, expected %0d", TBL_INDEX, (RETRY_ON ? 2 : 1));
      end
      nack_left = 0;
   endtask

   task automatic test_nack_always();
      clear_stats();
      nack_left = 1000;
      push_entry(0);
      for (int i = 0; i < ATTEMPTS; i++) push_entry(1);
      pulse_go();
      wait_run_end("nack_always", 1000);
      tick(5);
      checks++;
      if ({DONE, FAIL, BUSY} !== 3'b010 || TBL_INDEX !== 6'd1) begin
         errors++;
         $display("FAIL nack_always_status: DONE/FAIL/BUSY=%b idx=%0d, expected 010 idx=1",
                  {DONE, FAIL, BUSY}, TBL_INDEX);
      end
      checks++;
      if (start_count != 1 + ATTEMPTS || txr_count != ATTEMPTS || exp_q.size() != 0) begin
         errors++;
         $display("FAIL nack_always_attempts: start=%0d txr=%0d pending=%0d, expected %0d %0d 0",
                  start_count, txr_count, exp_q.size(), 1 + ATTEMPTS, ATTEMPTS);
      end
      nack_left = 0;
   endtask

   task automatic test_timeout();
      int n = 0;
      clear_stats();
      hang = 1'b1;
      for (int i = 0; i < ATTEMPTS; i++) push_entry(0);
      pulse_go();
      while (txr_count == 0 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (txr_count == 0) begin
         errors++;
         $display("FAIL timeout_recover: no TX_RESET within 400 cycles");
      end else if (first_txr_cyc - last_start_cyc != 255) begin
         errors++;
         $display("FAIL timeout_latency: TX_RESET %0d cycles after START, expected 255",
                  first_txr_cyc - last_start_cyc);
      end
      wait_run_end("timeout", 1500);
      checks++;
      if ({DONE, FAIL} !== 2'b01 || TBL_INDEX !== 6'd0 || txr_count != ATTEMPTS ||
          stop_count != 0) begin
         errors++;
         $display("FAIL timeout_abort: DONE/FAIL=%b idx=%0d txr=%0d stop=%0d, expected 01 0 %0d 0",
                  {DONE, FAIL}, TBL_INDEX, txr_count, stop_count, ATTEMPTS);
      end
      hang = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int n = 0;
      clear_stats();
      for (int i = 0; i < 3; i++) push_entry(i);
      pulse_go();
      while (start_count < 3 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (start_count < 3) begin
         errors++;
         $display("FAIL midrun_reach: start=%0d after 300 cycles, expected 3", start_count);
      end
      RESET = 1'b1;
      tick();
      checks++;
      if ({bus.START, bus.STOP, bus.TX_RESET, BUSY, DONE, FAIL, TBL_INDEX,
           bus.DEV_ADDR, bus.REG_ADDR, bus.DATA} !== 35'd0) begin
         errors++;
         $display("FAIL midrun_outputs: idx=%0d busy=%b reg=%h data=%h, expected all 0",
                  TBL_INDEX, BUSY, bus.REG_ADDR, bus.DATA);
      end
      tick();
      RESET = 1'b0;
      tick(2);
      checks++;
      if (txr_count != 0) begin
         errors++;
         $display("FAIL midrun_txr: TX_RESET pulses=%0d, expected 0", txr_count);
      end
      clear_stats();
      for (int i = 0; i < 3; i++) push_entry(i);
      pulse_go();
      checks++;
      if (TBL_INDEX !== 6'd0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL midrun_restart: idx=%0d BUSY=%b, expected 0 1", TBL_INDEX, BUSY);
      end
      wait_run_end("midrun", 400);
      checks++;
      if (DONE !== 1'b1 || start_count != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midrun_rerun: DONE=%b start=%0d pending=%0d, expected 1 3 0",
                  DONE, start_count, exp_q.size());
      end
   endtask

   task automatic test_go_held_ready_low();
      int n = 0;
      clear_stats();
      for (int i = 0; i < 3; i++) push_entry(i);
      ready_low = 1'b1;
      tick();
      GO = 1'b1;
      tick(50);
      checks++;
      if (start_count != 0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL ready_hold: start=%0d BUSY=%b while READY low, expected 0 1",
                  start_count, BUSY);
      end
      ready_low = 1'b0;
      while (DONE !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      GO = 1'b0;
      checks++;
      if (DONE !== 1'b1 || start_count != 3 || stop_count != 3) begin
         errors++;
         $display("FAIL go_held_run: DONE=%b start=%0d stop=%0d, expected 1 3 3",
                  DONE, start_count, stop_count);
      end
      tick(3);
      checks++;
      if (DONE !== 1'b1 || start_count != 3) begin
         errors++;
         $display("FAIL go_held_finish: DONE=%b start=%0d, expected 1 3", DONE, start_count);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      for (int i = 0; i < 64; i++) tbl[i] = {8'(8'h10 + i * 7), 8'(8'hC3 ^ (i * 5))};
      RESET = 1'b1;
      GO    = 1'b0;
      test_reset();
      test_basic_run();
      test_nack_once();
      test_nack_always();
      test_timeout();
      test_reset_midrun();
      test_go_held_ready_low();
      checks++;
      if (viol_count != 0) begin
         errors++;
         $display("FAIL protocol: %0d pulse overlap/width/index violations, expected 0", viol_count);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
